// File: rtl/icache_refill_pkg.sv
// Shared types and AXI constants for the instruction-cache refill engine.
package icache_refill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } refill_state_t;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

endpackage

// File: rtl/refill_line_buf.sv
// Line assembly buffer: places each R beat at its word slot and tracks a
// saturating beat count plus a sticky bad-response flag.
module refill_line_buf
    import icache_refill_pkg::*;
#(
    parameter int LINE_WORDS = 4
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             clr,
    input  logic [$clog2(LINE_WORDS)-1:0]    start_idx,
    input  logic                             beat_we,
    input  logic [31:0]                      beat_data,
    input  logic [1:0]                       beat_resp,
    output logic [32*LINE_WORDS-1:0]         line,
    output logic                             err,
    output logic [$clog2(LINE_WORDS):0]      cnt
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(LINE_WORDS);

    logic [31:0]      words [LINE_WORDS];
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            idx <= '0;
            cnt <= '0;
            err <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) words[i] <= '0;
        end else if (clr) begin
            idx <= start_idx;
            cnt <= '0;
            err <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) words[i] <= '0;
        end else if (beat_we) begin
            // Surplus beats past a full line only advance the index; the line is frozen.
            if (cnt < FULL) begin
                words[idx] <= beat_data;
                cnt        <= cnt + (IDX_W+1)'(1);
            end
            idx <= idx + IDX_W'(1);
            if (beat_resp != AXI_RESP_OKAY) err <= 1'b1;
        end
    end

    always_comb begin
        line = '0;
        for (int i = 0; i < LINE_WORDS; i++) line[32*i +: 32] = words[i];
    end

endmodule

// File: rtl/icache_axi_refill.sv
// I-cache miss refill engine: one AXI4 read burst per line, returned as a single pulse.
// Define ICACHE_REFILL_WRAP_EN for critical-word-first WRAP bursts (default INCR).
module icache_axi_refill
    import icache_refill_pkg::*;
#(
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] ARID_VAL   = 4'h0
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         rd_req,
    input  logic [31:0]                  rd_addr,
    output logic                         rd_rdy,
    output logic                         ret_valid,
    output logic [32*LINE_WORDS-1:0]     ret_data,
    output logic                         ret_err,
    output logic [3:0]                   arid,
    output logic [31:0]                  araddr,
    output logic [7:0]                   arlen,
    output logic [2:0]                   arsize,
    output logic [1:0]                   arburst,
    output logic                         arvalid,
    input  logic                         arready,
    input  logic [3:0]                   rid,
    input  logic [31:0]                  rdata,
    input  logic [1:0]                   rresp,
    input  logic                         rlast,
    input  logic                         rvalid,
    output logic                         rready
);

    localparam int IDX_W = $clog2(LINE_WORDS);

    refill_state_t    state;
    logic             accept;
    logic             beat_we;
    logic [IDX_W-1:0] start_idx;
    logic [31:0]      araddr_next;
    logic [IDX_W:0]   beat_cnt;
    logic             buf_err;
    logic             last_short;
    logic             unused_bits;

`ifdef ICACHE_REFILL_WRAP_EN
    assign start_idx   = rd_addr[IDX_W+1:2];
    assign araddr_next = {rd_addr[31:2], 2'b00};
    assign arburst     = AXI_BURST_WRAP;
`else
    assign start_idx   = '0;
    assign araddr_next = {rd_addr[31:IDX_W+2], {(IDX_W+2){1'b0}}};
    assign arburst     = AXI_BURST_INCR;
`endif

    assign arid        = ARID_VAL;
    assign arlen       = 8'(LINE_WORDS - 1);
    assign arsize      = AXI_SIZE_4B;
    assign unused_bits = ^{rid, rd_addr[IDX_W+1:0]};

    assign accept  = (state == ST_IDLE) && rd_req;
    assign beat_we = (state == ST_DATA) && rvalid;
    // beat_cnt is the count before the rlast beat lands, hence the -1.
    assign last_short = beat_cnt < (IDX_W+1)'(LINE_WORDS - 1);

    refill_line_buf #(
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buf (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (accept),
        .start_idx (start_idx),
        .beat_we   (beat_we),
        .beat_data (rdata),
        .beat_resp (rresp),
        .line      (ret_data),
        .err       (buf_err),
        .cnt       (beat_cnt)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            rd_rdy    <= 1'b1;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            ret_valid <= 1'b0;
            ret_err   <= 1'b0;
            araddr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_req) begin
                        araddr  <= araddr_next;
                        ret_err <= 1'b0;
                        arvalid <= 1'b1;
                        rd_rdy  <= 1'b0;
                        state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rvalid && rlast) begin
                        rready    <= 1'b0;
                        ret_valid <= 1'b1;
                        // Error covers any bad beat so far, this beat, or a short burst.
                        ret_err   <= buf_err || (rresp != AXI_RESP_OKAY) || last_short;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ret_valid <= 1'b0;
                    rd_rdy    <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_axi_refill.sv
// Scoreboard bench for icache_axi_refill: stimulus queues expected AR/line
// results, a negedge monitor compares them as the DUT presents them.
module tb_icache_axi_refill;

    logic         clk = 1'b0;
    logic         resetn;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic [127:0] ret_data;
    logic         ret_err;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    icache_axi_refill #(.LINE_WORDS(4), .ARID_VAL(4'h0)) dut (
        .clk(clk), .resetn(resetn), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_data(ret_data), .ret_err(ret_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

`ifdef ICACHE_REFILL_WRAP_EN
    localparam logic [1:0] EXP_BURST = 2'b10;
`else
    localparam logic [1:0] EXP_BURST = 2'b01;
`endif

    typedef struct {
        logic [127:0] data;
        logic         err;
        int           lat;
    } ret_t;

    ret_t        ret_q[$];
    logic [31:0] ar_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          t_req = 0;
    logic [31:0] bd [8];
    logic [1:0]  br [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare AR handshakes and returned lines against the queues.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (rd_req && rd_rdy) t_req = cyc;
            if (arvalid && arready) begin
                chk("ar_expected", 128'(ar_q.size() != 0), 128'd1);
                if (ar_q.size() != 0) begin
                    chk("araddr", 128'(araddr), 128'(ar_q.pop_front()));
                    chk("arlen", 128'(arlen), 128'd3);
                    chk("arburst", 128'(arburst), 128'(EXP_BURST));
                    chk("arsize_arid", 128'({arsize, arid}), 128'({3'b010, 4'h0}));
                end
            end
            if (ret_valid) begin
                chk("ret_expected", 128'(ret_q.size() != 0), 128'd1);
                if (ret_q.size() != 0) begin
                    ret_t e;
                    e = ret_q.pop_front();
                    chk("ret_data", ret_data, e.data);
                    chk("ret_err", 128'(ret_err), 128'(e.err));
                    chk("latency", 128'(cyc - t_req), 128'(e.lat));
                end
            end
        end
    end

    task automatic refill(input logic [31:0] addr, input logic [31:0] exp_ar, input int nb,
                          input int ar_wait, input int gap,
                          input logic [127:0] exp_data, input logic exp_err);
        ret_t e;
        e.data = exp_data;
        e.err  = exp_err;
        e.lat  = 2 + ar_wait + nb * (1 + gap);
        ret_q.push_back(e);
        ar_q.push_back(exp_ar);
        chk("rd_rdy_idle", 128'(rd_rdy), 128'd1);
        rd_req = 1'b1;
        rd_addr = addr;
        tick();
        rd_req = 1'b0;
        for (int i = 0; i < ar_wait; i++) begin
            chk("arvalid_hold", 128'(arvalid), 128'd1);
            chk("araddr_hold", 128'(araddr), 128'(exp_ar));
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < nb; b++) begin
            for (int g = 0; g < gap; g++) begin
                rvalid = 1'b0;
                chk("no_early_ret", 128'({ret_valid, rd_rdy}), 128'd0);
                tick();
            end
            rvalid = 1'b1;
            rdata  = bd[b];
            rresp  = br[b];
            rlast  = (b == nb - 1);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        chk("resp_cycle", 128'({ret_valid, rd_rdy}), 128'b10);
        tick();
        chk("after_resp", 128'({ret_valid, rd_rdy}), 128'b01);
    endtask

    task automatic set_beats(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] d3, input logic [31:0] d4, input logic [31:0] d5);
        bd[0] = d0; bd[1] = d1; bd[2] = d2; bd[3] = d3; bd[4] = d4; bd[5] = d5;
        for (int i = 0; i < 8; i++) br[i] = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; rd_req = 1'b0; rd_addr = '0; arready = 1'b0;
        rid = 4'h5; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        tick();
        tick();
        chk("reset_ctrl", 128'({rd_rdy, arvalid, rready, ret_valid, ret_err}), 128'b10000);
        chk("reset_data", ret_data, 128'd0);
        chk("reset_araddr", 128'(araddr), 128'd0);
        resetn = 1'b1;
        tick();

        // Basic zero-wait refill
        set_beats(32'h11, 32'h22, 32'h33, 32'h44, 0, 0);
        refill(32'h1FC0_0120, 32'h1FC0_0120, 4, 0, 0,
               128'h00000044_00000033_00000022_00000011, 1'b0);
        chk("ret_data_hold", ret_data, 128'h00000044_00000033_00000022_00000011);

        // AR and R backpressure
        set_beats(32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004, 0, 0);
        refill(32'h0000_2340, 32'h0000_2340, 4, 5, 2,
               128'hDEAD0004_DEAD0003_DEAD0002_DEAD0001, 1'b0);

        // SLVERR on beat 2, rlast on beat 3
        set_beats(32'hA1, 32'hA2, 32'hA3, 0, 0, 0);
        br[1] = 2'b10;
        refill(32'h0000_0400, 32'h0000_0400, 3, 0, 0,
               128'h00000000_000000A3_000000A2_000000A1, 1'b1);

        // Six beats, last two discarded
        set_beats(32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6);
        refill(32'h0000_0800, 32'h0000_0800, 6, 0, 0,
               128'h000000B4_000000B3_000000B2_000000B1, 1'b0);

        // Unaligned address: word order depends on burst mode
        set_beats(32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD, 0, 0);
`ifdef ICACHE_REFILL_WRAP_EN
        refill(32'h0000_0108, 32'h0000_0108, 4, 0, 0,
               128'hBBBBBBBB_AAAAAAAA_DDDDDDDD_CCCCCCCC, 1'b0);
`else
        refill(32'h0000_0108, 32'h0000_0100, 4, 0, 0,
               128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b0);
`endif

        // Reset after two DATA beats
        ar_q.push_back(32'h0000_0C00);
        rd_req = 1'b1;
        rd_addr = 32'h0000_0C00;
        tick();
        rd_req = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            rvalid = 1'b1;
            rdata = 32'hE0 + 32'(b);
            rresp = 2'b00;
            tick();
        end
        rvalid = 1'b0;
        resetn = 1'b0;
        tick();
        chk("midreset_ctrl", 128'({rd_rdy, arvalid, rready, ret_valid, ret_err}), 128'b10000);
        chk("midreset_data", ret_data, 128'd0);
        chk("midreset_araddr", 128'(araddr), 128'd0);
        resetn = 1'b1;
        tick();

        set_beats(32'hF1, 32'hF2, 32'hF3, 32'hF4, 0, 0);
        refill(32'h0000_1000, 32'h0000_1000, 4, 0, 0,
               128'h000000F4_000000F3_000000F2_000000F1, 1'b0);

        tick();
        tick();
        chk("ret_q_drained", 128'(ret_q.size()), 128'd0);
        chk("ar_q_drained", 128'(ar_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
